// File: rtl/jtag_host_pkg.sv
// Shared definitions for the host-side JTAG(esque) debug initiator and the
// uP-side port decoder: state encoding, frame TMS levels, opcodes.
package jtag_host_pkg;

  localparam int DEF_OP_W   = 4;
  localparam int DEF_DATA_W = 16;

  localparam logic TMS_START = 1'b1;
  localparam logic TMS_END   = 1'b1;

  // Opcodes understood by the uP-side debug port decoder
  localparam logic [DEF_OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [DEF_OP_W-1:0] OP_RD_REG = 4'h1;
  localparam logic [DEF_OP_W-1:0] OP_WR_REG = 4'h2;
  localparam logic [DEF_OP_W-1:0] OP_RD_MEM = 4'h3;
  localparam logic [DEF_OP_W-1:0] OP_WR_MEM = 4'h4;
  localparam logic [DEF_OP_W-1:0] OP_HALT   = 4'h8;
  localparam logic [DEF_OP_W-1:0] OP_RUN    = 4'h9;
  localparam logic [DEF_OP_W-1:0] OP_STEP   = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_OP,
    ST_DATA,
    ST_END,
    ST_RESP
  } state_t;

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: each bit is CLK_DIV low cycles followed by CLK_DIV high cycles,
// restarting from the low phase whenever run is deasserted.
module jtag_tck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic run,
  output logic o_tck,
  output logic o_bitStart,
  output logic o_sampleNow,
  output logic o_bitDone
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] phase;
  logic            high;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || !run) begin
      phase <= '0;
      high  <= 1'b0;
    end else if (phase == PH_LAST) begin
      phase <= '0;
      high  <= ~high;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign o_tck       = high;
  assign o_bitStart  = run & ~high & (phase == '0);
  assign o_sampleNow = run & high & (phase == PH_LAST);
  assign o_bitDone   = o_sampleNow;

endmodule

// File: rtl/jtag_host.sv
// Host-side JTAG(esque) initiator: frames opcode + data onto TCK/TMS/TDI and
// captures the TDO word shifted back during the DATA bits.
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int OP_W    = DEF_OP_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cmdValid,
  output logic              o_cmdReady,
  input  logic [OP_W-1:0]   i_cmdOp,
  input  logic [DATA_W-1:0] i_cmdData,
  output logic              o_rspValid,
  output logic [DATA_W-1:0] o_rspData,
  output logic              o_busy,
  output logic              o_TCK,
  output logic              o_TMS,
  output logic              o_TDI,
  input  logic              i_TDO
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] OP_LAST   = BC_W'(OP_W - 1);
  localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_W - 1);

  state_t            state;
  state_t            state_next;
  logic [BC_W-1:0]   bit_cnt;
  logic [OP_W-1:0]   op_sr;
  logic [DATA_W-1:0] data_sr;
  logic [1:0]        tdo_sync;
  logic              run;
  logic              accept;
  logic              last_bit;
  logic              bit_start;
  logic              sample_now;
  logic              bit_done;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .run         (run),
    .o_tck       (o_TCK),
    .o_bitStart  (bit_start),
    .o_sampleNow (sample_now),
    .o_bitDone   (bit_done)
  );

  assign accept   = o_cmdReady & i_cmdValid;
  assign last_bit = bit_done & (bit_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (i_cmdValid) state_next = ST_START;
      ST_START: if (last_bit)   state_next = ST_OP;
      ST_OP:    if (last_bit)   state_next = ST_DATA;
      ST_DATA:  if (last_bit)   state_next = ST_END;
      ST_END:   if (last_bit)   state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Pins derive from registered state, so they only move on the bit_done edge
  always_comb begin
    o_cmdReady = (state == ST_IDLE);
    o_rspValid = (state == ST_RESP);
    run        = (state == ST_START) || (state == ST_OP) ||
                 (state == ST_DATA)  || (state == ST_END);
    o_busy     = run;
    o_TMS      = 1'b0;
    o_TDI      = 1'b0;
    case (state)
      ST_START: o_TMS = TMS_START;
      ST_OP:    o_TDI = op_sr[0];
      ST_DATA:  o_TDI = data_sr[0];
      ST_END:   o_TMS = TMS_END;
      default:  ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) tdo_sync <= '0;
    else         tdo_sync <= {tdo_sync[0], i_TDO};
  end

  // data_sr shifts TDI out at the bottom while captured TDO fills from the top
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      bit_cnt   <= '0;
      op_sr     <= '0;
      data_sr   <= '0;
      o_rspData <= '0;
    end else begin
      if (accept) begin
        op_sr   <= i_cmdOp;
        data_sr <= i_cmdData;
        bit_cnt <= '0;
      end
      if (bit_done) begin
        if (bit_cnt != '0) begin
          bit_cnt <= bit_cnt - 1'b1;
        end else begin
          case (state)
            ST_START: bit_cnt <= OP_LAST;
            ST_OP:    bit_cnt <= DATA_LAST;
            default:  bit_cnt <= '0;
          endcase
        end
      end
      if ((state == ST_OP) && bit_done)
        op_sr <= op_sr >> 1;
      if ((state == ST_DATA) && sample_now)
        data_sr <= {tdo_sync[1], data_sr[DATA_W-1:1]};
      if ((state == ST_END) && last_bit)
        o_rspData <= data_sr;
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Directed self-checking bench for jtag_host at default parameters: frame
// shape, TDO capture, busy handling, back-to-back pacing and mid-frame reset.
module tb_jtag_host;

  localparam int OP_W   = 4;
  localparam int DATA_W = 16;
  localparam int DIV    = 4;
  localparam int NBITS  = 1 + OP_W + DATA_W + 1;
  localparam int FRAME  = 2 * NBITS * DIV;

  logic              clk = 1'b0;
  logic              rstn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              tck;
  logic              tms;
  logic              tdi;
  logic              tdo;

  int checks   = 0;
  int failures = 0;

  jtag_host dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_cmdValid (cmd_valid),
    .o_cmdReady (cmd_ready),
    .i_cmdOp    (cmd_op),
    .i_cmdData  (cmd_data),
    .o_rspValid (rsp_valid),
    .o_rspData  (rsp_data),
    .o_busy     (busy),
    .o_TCK      (tck),
    .o_TMS      (tms),
    .o_TDI      (tdi),
    .i_TDO      (tdo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] data);
    cmd_valid = valid;
    cmd_op    = op;
    cmd_data  = data;
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the
  // first IDLE cycle after the response (accept cycle + 178).
  task automatic runFrame(input string tag, input logic [OP_W-1:0] op,
                          input logic [DATA_W-1:0] data, input logic keep_valid,
                          input logic echo, input logic [DATA_W-1:0] pat,
                          input logic [NBITS-1:0] exp_tdi,
                          input logic [DATA_W-1:0] exp_rsp);
    logic [NBITS-1:0] exp_tms;
    int rsp_at;
    int pulses;
    int k;
    int off;
    exp_tms = 22'h200001;
    rsp_at  = -1;
    pulses  = 0;
    applyStimulus(1'b1, op, data);
    for (int j = 1; j <= FRAME + 2; j++) begin
      @(negedge clk);
      k   = (j - 1) / (2 * DIV);
      off = (j - 1) % (2 * DIV);
      if (rsp_valid) begin
        pulses++;
        if (rsp_at < 0) rsp_at = j;
      end
      if (j <= FRAME) begin
        if (off == 0) begin
          checkOutput({tag, "_tck_low"}, tck, 1'b0);
          checkOutput({tag, "_tms_low"}, tms, exp_tms[k]);
          checkOutput({tag, "_tdi_low"}, tdi, exp_tdi[k]);
          checkOutput({tag, "_busy"}, busy, 1'b1);
          if (echo)
            tdo = (k == 0) ? 1'b0 : exp_tdi[k-1];
          else if (k >= 1 + OP_W && k < 1 + OP_W + DATA_W)
            tdo = pat[k-1-OP_W];
          else
            tdo = 1'b1;
        end else if (off == 2 * DIV - 1) begin
          checkOutput({tag, "_tck_high"}, tck, 1'b1);
          checkOutput({tag, "_tms_high"}, tms, exp_tms[k]);
          checkOutput({tag, "_tdi_high"}, tdi, exp_tdi[k]);
        end
        if (j == 1 && !keep_valid) cmd_valid = 1'b0;
        if (j == 3) begin
          cmd_op   = ~op;
          cmd_data = ~data;
        end
      end else if (j == FRAME + 1) begin
        checkOutput({tag, "_resp_valid"}, rsp_valid, 1'b1);
        checkOutput({tag, "_resp_ready"}, cmd_ready, 1'b0);
        checkOutput({tag, "_resp_busy"}, busy, 1'b0);
        checkOutput({tag, "_resp_tck"}, tck, 1'b0);
        checkOutput({tag, "_rsp_data"}, rsp_data, exp_rsp);
      end else begin
        checkOutput({tag, "_ready_back"}, cmd_ready, 1'b1);
        checkOutput({tag, "_valid_gone"}, rsp_valid, 1'b0);
      end
    end
    checkOutput({tag, "_rsp_cycle"}, rsp_at, FRAME + 1);
    checkOutput({tag, "_rsp_pulses"}, pulses, 1);
  endtask

  initial begin
    int pulses;
    int pin_activity;
    rstn = 1'b0;
    tdo  = 1'b0;
    applyStimulus(1'b0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("reset_pins", {tck, tms, tdi}, 3'b000);
    checkOutput("reset_ready", cmd_ready, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 16'h0000);
    rstn = 1'b1;

    $display("[TB] idle for 50 cycles");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle", {tck, tms, tdi, rsp_valid, cmd_ready}, 5'b00001);
    end

    $display("[TB] op=A data=1234 with echoing TDO");
    runFrame("echo", 4'hA, 16'h1234, 1'b0, 1'b1, 16'h0000, 22'h024694, 16'h2469);

    $display("[TB] TDO pattern BEEF");
    runFrame("beef", 4'h3, 16'h00F0, 1'b0, 1'b0, 16'hBEEF, 22'h001E06, 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmd_data = 16'(i * 16'h1111);
    end
    checkOutput("beef_held", rsp_data, 16'hBEEF);
    checkOutput("beef_idle_ready", cmd_ready, 1'b1);

    $display("[TB] cmdValid held high across two frames");
    runFrame("held1", 4'h5, 16'hA5C3, 1'b1, 1'b1, 16'h0000, 22'h14B86A, 16'h4B86);
    runFrame("held2", 4'hF, 16'h0001, 1'b0, 1'b1, 16'h0000, 22'h00003E, 16'h0003);

    $display("[TB] reset during OP/DATA bit 10");
    applyStimulus(1'b1, 4'h9, 16'h7777);
    for (int j = 1; j <= 83; j++) begin
      @(negedge clk);
      if (j == 1) cmd_valid = 1'b0;
    end
    checkOutput("pre_reset_busy", busy, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midreset_pins", {tck, tms, tdi}, 3'b000);
    checkOutput("midreset_ready", cmd_ready, 1'b1);
    checkOutput("midreset_busy", busy, 1'b0);
    checkOutput("midreset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("midreset_rsp_data", rsp_data, 16'h0000);
    rstn = 1'b1;
    pulses = 0;
    pin_activity = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      if (tck || tms || tdi) pin_activity++;
    end
    checkOutput("postreset_no_rsp", pulses, 0);
    checkOutput("postreset_quiet_pins", pin_activity, 0);

    $display("[TB] frame after reset");
    runFrame("recover", 4'h6, 16'h8001, 1'b0, 1'b0, 16'hC3A5, 22'h10002C, 16'hC3A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
# jtag_host

Host-side initiator for the uP's JTAG(esque) debug port. It turns a parallel command (opcode plus 16-bit data word) into a framed serial sequence on TCK/TMS/TDI and captures the 16-bit TDO response. It sits in the debug/test fixture, on the FPGA or bench side, and drives the uP's `i_jtagTCK/i_jtagTMS/i_jtagTDI` pins while reading `o_jtagTDO`. The uP samples these pins through 2-flop synchronizers on its system clock, so TCK is a slow, divided clock.

## Interface
Parameters:
- `OP_W`, default 4: opcode width in bits.
- `DATA_W`, default 16: data/response width in bits.
- `CLK_DIV`, default 4: `i_clk` cycles per TCK half-period. Minimum 4; sized so the uP's synchronizers and TDO update settle.

Ports:
- `i_clk`  in  1: single clock. All logic is on the rising edge.
- `i_rstn`  in  1: reset, synchronous, active-low.
- `i_cmdValid`  in  1: command request.
- `o_cmdReady`  out  1: high only in IDLE. Transfer occurs when `i_cmdValid & o_cmdReady`.
- `i_cmdOp`  in  OP_W: opcode, shifted LSB first.
- `i_cmdData`  in  DATA_W: data word, shifted LSB first.
- `o_rspValid`  out  1: one-cycle pulse when the response is complete. No backpressure.
- `o_rspData`  out  DATA_W: captured TDO word. Held until the next response.
- `o_busy`  out  1: high from acceptance through the END bit.
- `o_TCK`, `o_TMS`, `o_TDI`  out  1 each: JTAG pins.
- `i_TDO`  in  1: JTAG return pin. Asynchronous to `i_clk`; synchronized internally with 2 flops.

## Operation
- Frame length is 1 + OP_W + DATA_W + 1 bits, which is 22 bits at the defaults.
  - START: TMS=1, TDI=0.
  - OP: OP_W bits, TMS=0, TDI=op[i].
  - DATA: DATA_W bits, TMS=0, TDI=data[i].
  - END: TMS=1, TDI=0.
- States: IDLE → START → OP → DATA → END → RESP → IDLE. Each serial state advances after its last bit completes.
- RESP lasts one cycle:
  - `o_rspValid`=1.
  - `o_rspData` is loaded from the shift register.
  - The FSM returns to IDLE.
- On acceptance, `i_cmdOp` and `i_cmdData` are latched into shift registers. Later input changes are ignored.
- TDO capture:
  - The synchronized TDO is sampled on the last `i_clk` cycle of each DATA bit's high phase.
  - Samples shift in LSB first, so the first DATA bit lands in `rspData[0]`.
  - TDO during START/OP/END is ignored.
- `i_cmdValid` during busy: ignored, not queued.
- A command presented in the RESP cycle is not accepted (ready=0). It is accepted on the following IDLE cycle.
- Reset values, and levels forced by reset mid-frame on the next edge:
  - `o_TCK`=0, `o_TMS`=0, `o_TDI`=0
  - `o_cmdReady`=1, `o_busy`=0
  - `o_rspValid`=0, `o_rspData`=0
  - FSM=IDLE, counters=0
- A reset mid-frame produces no response pulse. The partial frame is abandoned; the uP-side port resynchronizes on the next START.

## Timing
- Each bit has a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
- TMS and TDI change only on the first cycle of the low phase. They are stable across the rising TCK edge.
- In IDLE, TCK is low.
- Latency from accept edge T, with N = total frame bits:
  - Bit k low phase: cycles T+1+2k·DIV through T+(2k+1)·DIV.
  - Bit k high phase: the following DIV cycles.
  - `o_rspValid` is high in cycle T+2·N·DIV+1. With defaults: T+177.
- `o_cmdReady` returns high in cycle T+2·N·DIV+2.
- Back-to-back commands therefore have a minimum period of 2·N·DIV+2 = 178 cycles at the defaults.
- Counters:
  - Phase counter: width ceil(log2(CLK_DIV)). Wraps 0..DIV-1.
  - Bit counter: width ceil(log2(DATA_W+1)). Reloaded per state with (state bit count − 1) and counts down to 0.

## Structure
- Package `jtag_host_pkg` holds:
  - The state enum (IDLE, START, OP, DATA, END, RESP).
  - The START/END TMS constants.
  - The default OP_W/DATA_W.
  - The opcode constants shared with the uP-side port decoder.
- Sub-module `jtag_tck_gen` is the divider and phase generator. It takes `run` and outputs:
  - `o_tck`
  - `o_bitStart` (first low cycle)
  - `o_sampleNow` (last high cycle)
  - `o_bitDone`
- The FSM and shift registers live in `jtag_host`.

## Test plan
- Reset, then idle 50 cycles → TCK/TMS/TDI stay 0, ready=1, rspValid never pulses.
- Command op=4'hA, data=16'h1234, with TDO tied to a model echoing TDI one bit late:
  - TMS sequence is 1, 0×20, 1.
  - TDI sequence is 0, 0,1,0,1, LSB-first 0x1234, 0.
  - rspValid pulses at T+177.
- TDO driven with pattern 16'hBEEF, LSB first, changing on TCK falling edges → rspData=16'hBEEF, held until the next response.
- `i_cmdValid` held continuously high with changing data → a new acceptance only every 178 cycles; mid-frame data changes have no effect on TDI.
- Reset asserted on the 10th OP/DATA bit → next edge all pins 0, ready=1, no rspValid; the next command completes normally.
- CLK_DIV=8 build → bit period 16 cycles, rspValid at T+353, TMS/TDI stable ±DIV around each TCK rise.
